// File: rtl/iafu_snp_scheduler.sv
// Snoop-invalidate scheduler: four per-channel dedup FIFOs drained round-robin
// into a single registered valid/ready output stage.
module iafu_snp_scheduler #(
  parameter int MIG_GRP_SIZE = 8,
  parameter int FIFO_DEPTH   = 4,
  localparam int IDX_W = (MIG_GRP_SIZE > 1) ? $clog2(MIG_GRP_SIZE) : 1
) (
  input  logic             afu_clk,
  input  logic             afu_rst,
  input  logic             snp_inv    [4],
  input  logic [5:0]       snp_pg_off [4],
  input  logic [IDX_W-1:0] snp_idx    [4],
  input  logic             sched_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_pg_off,
  output logic [IDX_W-1:0] out_idx,
  output logic [1:0]       out_src,
  output logic             out_is_wr,
  output logic [3:0]       ovf_flag,
  output logic [15:0]      drop_cnt   [4],
  output logic             q_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 6 + IDX_W;

  typedef logic [ENT_W-1:0] ent_t;

  ent_t             r_mem  [4][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr [4];
  logic [PTR_W-1:0] r_rptr [4];
  logic [CNT_W-1:0] r_cnt  [4];
  logic [1:0]       r_last_grant;

  logic [3:0] w_nempty, w_pop_q, w_dup, w_full, w_push, w_drop;
  ent_t       w_ent  [4];
  ent_t       w_tail [4];
  ent_t       w_head;
  logic       w_pop, w_found;
  logic [1:0] w_sel, w_cand;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_sel   = r_last_grant + 2'd1;
    w_cand  = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_cand = r_last_grant + 2'(k);
      if (!w_found && w_nempty[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_pop  = sched_en & (|w_nempty) & (~out_valid | out_ready);
  assign w_head = r_mem[w_sel][r_rptr[w_sel]];

  // Dedup compares against the tail that remains after this cycle's pop, so a
  // repeat of the entry just leaving the queue is still delivered.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_nempty[i] = (r_cnt[i] != '0);
      w_ent[i]    = {snp_pg_off[i], snp_idx[i]};
      w_tail[i]   = r_mem[i][r_wptr[i] - 1'b1];
      w_pop_q[i]  = w_pop && (w_sel == 2'(i));
      w_dup[i]    = snp_inv[i] && w_nempty[i] && (w_tail[i] == w_ent[i]) &&
                    !(w_pop_q[i] && (r_cnt[i] == CNT_W'(1)));
      w_full[i]   = (r_cnt[i] == CNT_W'(FIFO_DEPTH)) && !w_pop_q[i];
      w_push[i]   = snp_inv[i] && !w_dup[i] && !w_full[i];
      w_drop[i]   = snp_inv[i] && !w_dup[i] && w_full[i];
    end
  end

  always_ff @(posedge afu_clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= w_ent[i];
    end
  end

  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_wptr[i]   <= '0;
        r_rptr[i]   <= '0;
        r_cnt[i]    <= '0;
        drop_cnt[i] <= '0;
      end
      ovf_flag     <= '0;
      r_last_grant <= 2'd3;
      out_valid    <= 1'b0;
      out_pg_off   <= '0;
      out_idx      <= '0;
      out_src      <= '0;
      out_is_wr    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_push[i])  r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop_q[i]) r_rptr[i] <= r_rptr[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop_q[i]);
        if (w_drop[i]) begin
          ovf_flag[i] <= 1'b1;
          if (drop_cnt[i] != '1) drop_cnt[i] <= drop_cnt[i] + 16'd1;
        end
      end
      if (w_pop) begin
        out_valid    <= 1'b1;
        out_pg_off   <= w_head[ENT_W-1 -: 6];
        out_idx      <= w_head[IDX_W-1:0];
        out_src      <= w_sel;
        out_is_wr    <= w_sel[1];
        r_last_grant <= w_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign q_empty = ~(|w_nempty) & ~out_valid;

endmodule

// File: tb/tb_iafu_snp_scheduler.sv
// Randomized bench for iafu_snp_scheduler against a queue-based reference model,
// plus short directed scenarios for the documented corner cases.
module tb_iafu_snp_scheduler;

  localparam int MIG_GRP_SIZE = 8;
  localparam int FIFO_DEPTH   = 4;
  localparam int IDX_W        = $clog2(MIG_GRP_SIZE);

  typedef logic [6+IDX_W-1:0] ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             snp_inv    [4];
  logic [5:0]       snp_pg_off [4];
  logic [IDX_W-1:0] snp_idx    [4];
  logic             sched_en, out_ready;
  logic             out_valid, out_is_wr, q_empty;
  logic [5:0]       out_pg_off;
  logic [IDX_W-1:0] out_idx;
  logic [1:0]       out_src;
  logic [3:0]       ovf_flag;
  logic [15:0]      drop_cnt [4];

  iafu_snp_scheduler #(.MIG_GRP_SIZE(MIG_GRP_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .afu_clk(clk), .afu_rst(rst), .snp_inv(snp_inv), .snp_pg_off(snp_pg_off),
    .snp_idx(snp_idx), .sched_en(sched_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_pg_off(out_pg_off), .out_idx(out_idx),
    .out_src(out_src), .out_is_wr(out_is_wr), .ovf_flag(ovf_flag),
    .drop_cnt(drop_cnt), .q_empty(q_empty)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t       mq [4][$];
  int         m_lg;
  bit         m_ov;
  ent_t       m_ent;
  int         m_src;
  bit   [3:0] m_ovf;
  int         m_drop [4];

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_drop[i] = 0;
    end
    m_lg = 3; m_ov = 0; m_ent = '0; m_src = 0; m_ovf = '0;
  endtask

  task automatic model_step();
    bit   any;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    any = 0;
    for (int i = 0; i < 4; i++) if (mq[i].size() > 0) any = 1;
    if (m_ov && out_ready) m_ov = 0;
    if (sched_en && any && (m_ov == 0)) begin
      for (int k = 1; k <= 4; k++) begin
        int c = (m_lg + k) % 4;
        if (mq[c].size() > 0) begin
          m_ent = mq[c].pop_front();
          m_src = c;
          m_lg  = c;
          m_ov  = 1;
          break;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (snp_inv[i]) begin
        e = {snp_pg_off[i], snp_idx[i]};
        if (mq[i].size() > 0 && mq[i][mq[i].size()-1] == e) begin
          // collapsed into the queued tail
        end else if (mq[i].size() >= FIFO_DEPTH) begin
          m_ovf[i] = 1'b1;
          if (m_drop[i] < 16'hFFFF) m_drop[i]++;
        end else begin
          mq[i].push_back(e);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit emp;
    emp = !m_ov;
    for (int i = 0; i < 4; i++) if (mq[i].size() > 0) emp = 0;
    check({tag, "_valid"}, 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check({tag, "_pg"},  32'(out_pg_off), 32'(m_ent[6+IDX_W-1 -: 6]));
      check({tag, "_idx"}, 32'(out_idx),    32'(m_ent[IDX_W-1:0]));
      check({tag, "_src"}, 32'(out_src),    32'(m_src));
      check({tag, "_wr"},  32'(out_is_wr),  32'(m_src >= 2));
    end
    check({tag, "_qempty"}, 32'(q_empty), 32'(emp));
    check({tag, "_ovf"},    32'(ovf_flag), 32'(m_ovf));
    for (int i = 0; i < 4; i++) check($sformatf("%s_drop%0d", tag, i), 32'(drop_cnt[i]), 32'(m_drop[i]));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic clear_inv();
    for (int i = 0; i < 4; i++) snp_inv[i] = 1'b0;
  endtask

  task automatic set_inv(input int ch, input logic [5:0] pg, input logic [IDX_W-1:0] idx);
    snp_inv[ch] = 1'b1; snp_pg_off[ch] = pg; snp_idx[ch] = idx;
  endtask

  // Asynchronous reset applied mid-cycle; outputs checked before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    clear_inv();
    cycle("rst_hold");
    cycle("rst_hold");
    rst = 1'b0;
  endtask

  int n_out;

  initial begin
    rst = 1'b1; sched_en = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      snp_inv[i] = 1'b0; snp_pg_off[i] = '0; snp_idx[i] = '0;
    end
    model_reset();
    #2;
    check_all("rst_init");
    cycle("rst_init");
    cycle("rst_init");
    rst = 1'b0;

    // Single write-channel event, two-cycle latency, one cycle wide
    sched_en = 1; out_ready = 1;
    set_inv(2, 6'h15, 3'd3);
    cycle("d030");
    clear_inv();
    cycle("d030");
    check("d030_valid", 32'(out_valid), 1);
    check("d030_pg", 32'(out_pg_off), 32'h15);
    check("d030_src", 32'(out_src), 2);
    check("d030_wr", 32'(out_is_wr), 1);
    cycle("d030");
    check("d030_width", 32'(out_valid), 0);

    // Simultaneous events on all channels drain in order 0..3
    do_reset();
    sched_en = 1; out_ready = 1;
    for (int i = 0; i < 4; i++) set_inv(i, 6'(i + 8), 3'(i));
    cycle("d031");
    clear_inv();
    for (int k = 0; k < 4; k++) begin
      cycle("d031");
      check("d031_order", 32'(out_src), 32'(k));
    end
    set_inv(1, 6'h2A, 3'd5);
    cycle("d031");
    clear_inv();
    cycle("d031");
    check("d031_next", 32'(out_src), 1);

    // Backpressure: six pushes on ch 0 with consumer stalled
    do_reset();
    sched_en = 1; out_ready = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) set_inv(0, 6'(c + 1), 3'(c)); else clear_inv();
      cycle("d032");
    end
    check("d032_pg", 32'(out_pg_off), 1);
    check("d032_ovf", 32'(ovf_flag[0]), 1);
    check("d032_drop", 32'(drop_cnt[0]), 1);
    out_ready = 1;
    for (int c = 0; c < 6; c++) cycle("d032_drain");

    // Duplicate pushes collapse while the scheduler is idle
    do_reset();
    sched_en = 0; out_ready = 1;
    set_inv(3, 6'h07, 3'd1);
    cycle("d033");
    cycle("d033");
    clear_inv();
    cycle("d033");
    sched_en = 1;
    n_out = 0;
    for (int c = 0; c < 5; c++) begin
      cycle("d033");
      if (out_valid) n_out++;
    end
    check("d033_outs", 32'(n_out), 1);
    check("d033_drop", 32'(drop_cnt[3]), 0);

    // Push into a full queue in the same cycle it is popped
    do_reset();
    sched_en = 0; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      set_inv(1, 6'(c + 20), 3'(c));
      cycle("d034_fill");
    end
    sched_en = 1;
    set_inv(1, 6'h30, 3'd7);
    cycle("d034");
    clear_inv();
    check("d034_ovf", 32'(ovf_flag[1]), 0);
    for (int c = 0; c < 7; c++) cycle("d034_drain");

    // Reset while an output is pending and queues hold data
    sched_en = 1; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      set_inv(c, 6'(c + 40), 3'(c));
      cycle("d035_load");
    end
    clear_inv();
    do_reset();
    check("d035_qempty", 32'(q_empty), 1);
    check("d035_valid", 32'(out_valid), 0);
    sched_en = 1; out_ready = 1;
    set_inv(0, 6'h3F, 3'd2);
    cycle("d035_post");
    clear_inv();
    cycle("d035_post");
    check("d035_post_valid", 32'(out_valid), 1);
    check("d035_post_pg", 32'(out_pg_off), 32'h3F);

    // Randomized traffic with narrow payloads so dedup and overflow occur often
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        snp_inv[i]    = ($urandom_range(0, 99) < 35);
        snp_pg_off[i] = 6'($urandom_range(0, 3));
        snp_idx[i]    = IDX_W'($urandom_range(0, 1));
      end
      sched_en  = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/iafu_snp_scheduler.md
IAFU_SNP_SCHEDULER -- requirements
Module: iafu_snp_scheduler

Interface
REQ-001 SHALL have parameter MIG_GRP_SIZE, default 8: number of tracked migration pages; IDX_W = clog2(MIG_GRP_SIZE).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: entries per snoop-channel queue, power of two, >= 2.
REQ-003 SHALL have port afu_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port afu_rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port snp_inv, input, 1 x4 (unpacked): per-channel snoop hit pulse (0=c0 read, 1=c1 read, 2=c0 write, 3=c1 write).
REQ-006 SHALL have port snp_pg_off, input, 6 x4: 64B line offset within the 4KB page, valid with snp_inv.
REQ-007 SHALL have port snp_idx, input, IDX_W x4: migration-group slot index, valid with snp_inv.
REQ-008 SHALL have port sched_en, input, 1: 1 = arbitrate and drain queues; 0 = queues fill, no grant.
REQ-009 SHALL have port out_valid, output, 1: scheduled invalidation available.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts when out_valid & out_ready.
REQ-011 SHALL have ports out_pg_off (6), out_idx (IDX_W), out_src (2), out_is_wr (1), outputs: payload; out_is_wr = out_src[1].
REQ-012 SHALL have port ovf_flag, output, 4: sticky per-channel overflow indicator.
REQ-013 SHALL have port drop_cnt, output, 16 x4: per-channel saturating dropped-event counter.
REQ-014 SHALL have port q_empty, output, 1: all four queues empty and out_valid = 0.

Function
REQ-015 SHALL push {snp_pg_off[i], snp_idx[i]} into queue i in the cycle snp_inv[i] = 1, for every i independently (up to 4 pushes per cycle).
REQ-016 SHALL accept a push to a full queue only if that queue is popped in the same cycle; otherwise drop it, set ovf_flag[i], increment drop_cnt[i] saturating at 16'hFFFF.
REQ-017 SHALL collapse a push identical in {pg_off, idx} to queue i's current tail entry (entry still queued): no new entry, no drop count.
REQ-018 SHALL use an output register stage: a pop occurs when sched_en = 1, at least one queue non-empty, and (out_valid = 0 or out_ready = 1).
REQ-019 SHALL select the popped queue round-robin: search starts at last_grant+1 mod 4; last_grant resets to 3 (so channel 0 has first priority).
REQ-020 SHALL update last_grant only on a pop.
REQ-021 SHALL load out_* from the popped entry and set out_valid = 1 in the cycle following the pop decision; minimum latency snp_inv -> out_valid = 2 cycles (push cycle, pop cycle).
REQ-022 SHALL hold out_* stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL clear out_valid after a handshake when no pop occurs in that cycle; back-to-back handshakes at one per cycle SHALL be sustained.
REQ-024 SHALL, when sched_en deasserts, still complete any pending out_valid handshake but perform no further pops.
REQ-025 SHALL not let a push to queue i become visible to arbitration in the same cycle (push-then-pop ordering per queue, FIFO order preserved).
REQ-026 SHALL compute q_empty combinationally from queue occupancies and out_valid.

Reset
REQ-027 SHALL, on afu_rst = 1 (asynchronous), clear all queues, out_valid, out_pg_off, out_idx, out_src, out_is_wr, ovf_flag, drop_cnt to 0, last_grant to 3; q_empty = 1.
REQ-028 SHALL discard events in flight when reset asserts mid-operation; no output handshake completes during reset.
REQ-029 SHALL accept snp_inv in the first cycle after afu_rst deasserts.

Verification
REQ-030 Single event: snp_inv[2]=1, pg_off=0x15, idx=3, sched_en=1, out_ready=1 -> 2 cycles later out_valid=1, out_pg_off=0x15, out_idx=3, out_src=2, out_is_wr=1, one cycle wide.
REQ-031 Simultaneous: all four snp_inv=1 in one cycle with distinct offsets, out_ready=1 -> outputs in order src 0,1,2,3 on four consecutive cycles; then next event on ch 1 only -> src 1.
REQ-032 Backpressure: out_ready=0 for 10 cycles with 6 pushes on ch 0, FIFO_DEPTH=4 -> payload stable, ch 0 holds 4 queued + 1 in output register, ovf_flag[0]=1, drop_cnt[0]=1.
REQ-033 Dedup: ch 3 pushes {0x07,1} two consecutive cycles with sched_en=0 -> one entry; enabling yields exactly one output, drop_cnt[3]=0.
REQ-034 Full with pop: ch 1 full, sched_en=1, out_ready=1, push same cycle as pop of ch 1 -> accepted, ovf_flag[1] stays 0.
REQ-035 Reset mid-stream: afu_rst pulse while out_valid=1 and queues non-empty -> out_valid=0, q_empty=1, counters 0 immediately; next event after release serviced normally.
